dvi_timing_gen: RTL and testbench

DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

---
 rtl/dvi_timing_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_dvi_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator with a pixel-request lookahead port and
// built-in test patterns (colour bars, solid, gradient).
module dvi_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int COLOR_W   = 8,
  parameter int X_POS_W   = 10,
  parameter int Y_POS_W   = 10,
  parameter int LOOKAHEAD = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [1:0]             pattern_sel_i,
  input  logic [3*COLOR_W-1:0]   solid_rgb_i,
  input  logic [COLOR_W-1:0]     red_i,
  input  logic [COLOR_W-1:0]     green_i,
  input  logic [COLOR_W-1:0]     blue_i,
  output logic [X_POS_W-1:0]     x_o,
  output logic [Y_POS_W-1:0]     y_o,
  output logic                   req_o,
  output logic                   line_start_o,
  output logic                   frame_start_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   de_o,
  output logic [COLOR_W-1:0]     red_o,
  output logic [COLOR_W-1:0]     green_o,
  output logic [COLOR_W-1:0]     blue_o,
  output logic                   running_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int BW      = H_ACTIVE / 8;
  localparam int XD      = (LOOKAHEAD == 0) ? 1 : LOOKAHEAD;
  localparam logic HP    = (H_POL != 0);
  localparam logic VP    = (V_POL != 0);

  if (H_TOTAL - 1 > 2 ** X_POS_W - 1) begin : g_err_h
    $error("H_TOTAL does not fit in X_POS_W");
  end
  if (V_TOTAL - 1 > 2 ** Y_POS_W - 1) begin : g_err_v
    $error("V_TOTAL does not fit in Y_POS_W");
  end
  if (H_ACTIVE < 8) begin : g_err_bars
    $error("H_ACTIVE must be at least 8");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD > 15) begin : g_err_la
    $error("LOOKAHEAD out of range 0..15");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [X_POS_W-1:0]   h_q;
  logic [Y_POS_W-1:0]   v_q;
  logic [X_POS_W-1:0]   bar_pos_q;
  logic [2:0]           bar_idx_q;
  logic [1:0]           pat_q;
  logic                 running, h_last, v_last, frame_cycle;
  logic                 hs_raw, vs_raw, req;

  assign running     = (state_q == RUN);
  assign h_last      = (int'(h_q) == H_TOTAL - 1);
  assign v_last      = (int'(v_q) == V_TOTAL - 1);
  assign frame_cycle = (h_q == '0) && (v_q == '0);

  // A stop request is only honoured on the last pixel, so a frame always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (h_last && v_last && !en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !running) begin
      h_q       <= '0;
      v_q       <= '0;
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else begin
      if (h_last) begin
        h_q <= '0;
        v_q <= v_last ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
      // Bar index stepped by a width counter; bar 7 (black) soaks up the remainder.
      if (h_last) begin
        bar_pos_q <= '0;
        bar_idx_q <= '0;
      end else if (int'(bar_pos_q) == BW - 1) begin
        bar_pos_q <= '0;
        if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_pos_q <= bar_pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)            pat_q <= 2'd0;
    else if (frame_cycle) pat_q <= pattern_sel_i;
  end

  assign hs_raw = running && (int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END);
  assign vs_raw = running && (int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END);
  assign req    = running && (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);

  // req_o/x_o/y_o at cycle t pair with red_i/green_i/blue_i at t+LOOKAHEAD;
  // de_o and the pixel for that request appear together at t+LOOKAHEAD+1.
  logic [LOOKAHEAD:0]  hs_p, vs_p, de_p;
  logic [X_POS_W-1:0]  x_p   [XD];
  logic [Y_POS_W-1:0]  y_p   [XD];
  logic [2:0]          bar_p [XD];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_p <= '0;
      vs_p <= '0;
      de_p <= '0;
      for (int i = 0; i < XD; i++) begin
        x_p[i]   <= '0;
        y_p[i]   <= '0;
        bar_p[i] <= '0;
      end
    end else begin
      hs_p[0]  <= hs_raw;
      vs_p[0]  <= vs_raw;
      de_p[0]  <= req;
      x_p[0]   <= h_q;
      y_p[0]   <= v_q;
      bar_p[0] <= bar_idx_q;
      for (int i = 1; i <= LOOKAHEAD; i++) begin
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        de_p[i] <= de_p[i-1];
      end
      for (int i = 1; i < XD; i++) begin
        x_p[i]   <= x_p[i-1];
        y_p[i]   <= y_p[i-1];
        bar_p[i] <= bar_p[i-1];
      end
    end
  end

  logic [X_POS_W-1:0] x_d;
  logic [Y_POS_W-1:0] y_d;
  logic [2:0]         bar_d;
  logic               de_d;
  logic [1:0]         pat_now;

  if (LOOKAHEAD == 0) begin : g_tap0
    assign x_d     = h_q;
    assign y_d     = v_q;
    assign bar_d   = bar_idx_q;
    assign de_d    = req;
    assign pat_now = frame_cycle ? pattern_sel_i : pat_q;
  end else begin : g_tapn
    assign x_d     = x_p[LOOKAHEAD-1];
    assign y_d     = y_p[LOOKAHEAD-1];
    assign bar_d   = bar_p[LOOKAHEAD-1];
    assign de_d    = de_p[LOOKAHEAD-1];
    assign pat_now = pat_q;
  end

  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (pat_now)
      2'd0: begin
        pix_r = red_i;
        pix_g = green_i;
        pix_b = blue_i;
      end
      2'd1: begin
        // Bar order white..black maps to {r,g,b} = ~{idx[1], idx[2], idx[0]}.
        pix_r = {COLOR_W{~bar_d[1]}};
        pix_g = {COLOR_W{~bar_d[2]}};
        pix_b = {COLOR_W{~bar_d[0]}};
      end
      2'd2: {pix_r, pix_g, pix_b} = solid_rgb_i;
      default: begin
        pix_r = COLOR_W'(x_d);
        pix_g = COLOR_W'(y_d);
        pix_b = COLOR_W'(x_d) + COLOR_W'(y_d);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !de_d) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else begin
      red_o   <= pix_r;
      green_o <= pix_g;
      blue_o  <= pix_b;
    end
  end

  assign hsync_o       = hs_p[LOOKAHEAD] ? HP : ~HP;
  assign vsync_o       = vs_p[LOOKAHEAD] ? VP : ~VP;
  assign de_o          = de_p[LOOKAHEAD];
  assign x_o           = h_q;
  assign y_o           = v_q;
  assign req_o         = req;
  assign line_start_o  = running && (h_q == '0);
  assign frame_start_o = running && frame_cycle;
  assign running_o     = running;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen on a tiny 14x7 raster (H 8/2/2/2, V 4/1/1/1, LOOKAHEAD 2).
module tb_dvi_timing_gen;

  logic        clk = 1'b0;
  logic        rst_i, en_i;
  logic [1:0]  pattern_sel_i;
  logic [23:0] solid_rgb_i;
  logic [7:0]  red_i, green_i, blue_i;
  logic [9:0]  x_o, y_o;
  logic        req_o, line_start_o, frame_start_o, hsync_o, vsync_o, de_o, running_o;
  logic [7:0]  red_o, green_o, blue_o;

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(0), .COLOR_W(8), .X_POS_W(10), .Y_POS_W(10), .LOOKAHEAD(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pattern_sel_i(pattern_sel_i),
    .solid_rgb_i(solid_rgb_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .x_o(x_o), .y_o(y_o), .req_o(req_o), .line_start_o(line_start_o),
    .frame_start_o(frame_start_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .running_o(running_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // raster window seen by the monitor: counters live in [f0, run_end], outputs in [f0+3, out_end]
  int f0 = 1000000000;
  int run_end = -1;
  int out_end = -1;

  logic [23:0] exp_q[$];

  logic [7:0] bar_r [8] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [7:0] bar_g [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] bar_b [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pixel(input int mode, input int x, input int y);
    logic [23:0] e;
    case (mode)
      0:       e = {8'(x), 8'(y), 8'(x) ^ 8'h3C};
      1:       e = {bar_r[x], bar_g[x], bar_b[x]};
      2:       e = 24'h123456;
      default: e = {8'(x), 8'(y), 8'(x + y)};
    endcase
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int mode);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        push_pixel(mode, x, y);
  endtask

  // driver: external source answers x_o/y_o two cycles later
  logic [9:0] xh1 = '0, xh2 = '0, yh1 = '0, yh2 = '0;
  initial begin
    red_i = '0; green_i = '0; blue_i = '0;
    forever begin
      @(negedge clk);
      red_i   = xh2[7:0];
      green_i = yh2[7:0];
      blue_i  = xh2[7:0] ^ 8'h3C;
      xh2 = xh1; yh2 = yh1;
      xh1 = x_o; yh1 = y_o;
    end
  end

  // monitor: raster position model plus pixel scoreboard keyed on de_o
  initial begin
    int c, p, h, v, q;
    logic ex_hs, ex_vs, ex_de;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c >= 1) begin
        if (c >= f0 && c <= run_end) begin
          p = c - f0; h = p % 14; v = (p / 14) % 7;
          check("x_o", x_o, h);
          check("y_o", y_o, v);
          check("req_o", req_o, (h < 8 && v < 4));
          check("line_start_o", line_start_o, (h == 0));
          check("frame_start_o", frame_start_o, (h == 0 && v == 0));
          check("running_o", running_o, 1);
        end else begin
          check("idle_x_o", x_o, 0);
          check("idle_y_o", y_o, 0);
          check("idle_req_o", req_o, 0);
          check("idle_line_start_o", line_start_o, 0);
          check("idle_frame_start_o", frame_start_o, 0);
          check("idle_running_o", running_o, 0);
        end
        if (c >= f0 + 3 && c <= out_end) begin
          q = c - f0 - 3; h = q % 14; v = (q / 14) % 7;
          ex_hs = !(h == 10 || h == 11);
          ex_vs = !(v == 5);
          ex_de = (h < 8 && v < 4);
        end else begin
          ex_hs = 1'b1; ex_vs = 1'b1; ex_de = 1'b0;
        end
        check("hsync_o", hsync_o, ex_hs);
        check("vsync_o", vsync_o, ex_vs);
        check("de_o", de_o, ex_de);
        if (de_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pix_unexpected cyc=%0d actual=%0h expected=none", c, {red_o, green_o, blue_o});
          end else begin
            check("pix_rgb", {red_o, green_o, blue_o}, exp_q.pop_front());
          end
        end else begin
          check("blank_rgb", {red_o, green_o, blue_o}, 0);
        end
      end
    end
  end

  // stimulus
  initial begin
    int r;
    rst_i = 1'b1; en_i = 1'b0; pattern_sel_i = 2'd0; solid_rgb_i = 24'h123456;
    goto(3);
    rst_i = 1'b0;
    goto(4);
    @(negedge clk);
    check("rst_hsync", hsync_o, 1);
    check("rst_vsync", vsync_o, 1);
    check("rst_de", de_o, 0);
    check("rst_running", running_o, 0);

    // six frames: ext, ext, bars, solid, gradient, ext; stop requested at v=2 of the last
    goto(10);
    push_frame(0); push_frame(0); push_frame(1);
    push_frame(2); push_frame(3); push_frame(0);
    f0 = 11; run_end = 1000000000; out_end = 1000000000;
    en_i = 1'b1;
    goto(f0 + 148); pattern_sel_i = 2'd1;
    goto(f0 + 246); pattern_sel_i = 2'd2;
    goto(f0 + 344); pattern_sel_i = 2'd3;
    goto(f0 + 442); pattern_sel_i = 2'd0;
    goto(f0 + 520); en_i = 1'b0;
    run_end = f0 + 587; out_end = f0 + 590;
    goto(f0 + 600);

    // restart; en dropped at v=2 and re-raised at v=5, then reset mid-line of frame 1
    push_frame(0);
    for (int x = 0; x < 8; x++) push_pixel(0, x, 0);
    for (int x = 0; x < 4; x++) push_pixel(0, x, 1);
    f0 = cyc + 1; run_end = 1000000000; out_end = 1000000000;
    en_i = 1'b1;
    goto(f0 + 30); en_i = 1'b0;
    goto(f0 + 75); en_i = 1'b1;
    r = f0 + 118;
    goto(r);
    rst_i = 1'b1; en_i = 1'b0;
    run_end = r; out_end = r;
    goto(r + 1);
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_hsync", hsync_o, 1);
    check("midrst_vsync", vsync_o, 1);
    check("midrst_de", de_o, 0);
    check("midrst_rgb", {red_o, green_o, blue_o}, 0);
    check("midrst_running", running_o, 0);
    goto(r + 10);
    check("pix_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
